// File: rtl/dmem_responder.sv
// Data-side memory responder: single outstanding request against an internal
// doubleword RAM, {data, fault} response after LATENCY cycles. Swap via DMEM_RESPONDER_AMO_EN.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_enable,
    input  logic [1:0]  req_op,
    input  logic [7:0]  req_mask,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_data,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [63:0] resp_data,
    output logic [1:0]  resp_fault,
    output logic        req_dropped
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [63:0] SPAN  = 64'(DEPTH_WORDS) << 3;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [1:0] F_OK       = 2'b00;
    localparam logic [1:0] F_MISALIGN = 2'b01;
    localparam logic [1:0] F_ACCESS   = 2'b10;
    localparam logic [1:0] F_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    logic [63:0]      mem [DEPTH_WORDS];
    state_t           state, state_d;
    logic [1:0]       cnt, cnt_d;
    logic             accept;
    logic [63:0]      offset;
    logic [IDX_W-1:0] idx;
    logic [63:0]      lane_mask;
    logic [63:0]      rd_word;
    logic [63:0]      wr_word;
    logic             illegal, misaligned, out_of_range;
    logic [1:0]       fault_c;
    logic             returns_data;
    logic             we;
    logic [63:0]      result;
    logic [63:0]      pend_data;
    logic [1:0]       pend_fault;
    logic             ready_d, valid_d, dropped_d;
    logic [63:0]      data_d;
    logic [1:0]       fault_d;

    // Request decode; negative offsets wrap to huge unsigned values and fault.
    assign accept       = req_enable && req_ready;
    assign offset       = req_addr - BASE_ADDR;
    assign out_of_range = offset >= SPAN;
    assign idx          = offset[IDX_W+2:3];
    assign rd_word      = mem[idx];
    assign misaligned   = (req_mask == 8'h00) || !req_mask[req_addr[2:0]];

    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < 8; b++) begin
            lane_mask[b*8 +: 8] = {8{req_mask[b]}};
        end
    end

`ifdef DMEM_RESPONDER_AMO_EN
    assign illegal      = (req_op == OP_RSVD);
    assign returns_data = (req_op == OP_LOAD) || (req_op == OP_SWAP);
    assign we           = accept && (fault_c == F_OK) &&
                          ((req_op == OP_STORE) || (req_op == OP_SWAP));
`else
    assign illegal      = (req_op == OP_RSVD) || (req_op == OP_SWAP);
    assign returns_data = (req_op == OP_LOAD);
    assign we           = accept && (fault_c == F_OK) && (req_op == OP_STORE);
`endif

    always_comb begin
        fault_c = F_OK;
        if (illegal)           fault_c = F_ILLEGAL;
        else if (misaligned)   fault_c = F_MISALIGN;
        else if (out_of_range) fault_c = F_ACCESS;
    end

    assign result  = ((fault_c == F_OK) && returns_data) ? (rd_word & lane_mask) : 64'h0;
    assign wr_word = (rd_word & ~lane_mask) | (req_data & lane_mask);

    // RAM commits at the acceptance edge; contents are intentionally not reset.
    always_ff @(posedge CLK) begin
        if (we) mem[idx] <= wr_word;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 2'(LATENCY - 2);
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 2'd0) state_d = S_RESP;
                else             cnt_d   = cnt - 2'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values for the registered outputs; response payload moves only on entry to RESP.
    always_comb begin
        ready_d   = (state_d == S_IDLE);
        valid_d   = (state_d == S_RESP);
        data_d    = resp_data;
        fault_d   = resp_fault;
        dropped_d = req_dropped || (req_enable && !req_ready);
        if (state_d == S_RESP) begin
            data_d  = accept ? result  : pend_data;
            fault_d = accept ? fault_c : pend_fault;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_data   <= 64'h0;
            resp_fault  <= F_OK;
            req_dropped <= 1'b0;
            pend_data   <= 64'h0;
            pend_fault  <= F_OK;
        end else begin
            req_ready   <= ready_d;
            resp_valid  <= valid_d;
            resp_data   <= data_d;
            resp_fault  <= fault_d;
            req_dropped <= dropped_d;
            if (accept) begin
                pend_data  <= result;
                pend_fault <= fault_c;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=1, one at LATENCY=3,
// both driven by the same request stream.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_enable;
    logic [1:0]  req_op;
    logic [7:0]  req_mask;
    logic [63:0] req_addr;
    logic [63:0] req_data;

    logic        rdy_a, vld_a, drop_a;
    logic [63:0] data_a;
    logic [1:0]  fault_a;
    logic        rdy_b, vld_b, drop_b;
    logic [63:0] data_b;
    logic [1:0]  fault_b;

    int checks = 0;
    int errors = 0;

    logic [6:0] rdy_hist_a, rdy_hist_b;
    int         vld_cnt;

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(1)) u_dut_a (
        .CLK(clk), .RESET(rst),
        .req_enable(req_enable), .req_op(req_op), .req_mask(req_mask),
        .req_addr(req_addr), .req_data(req_data),
        .req_ready(rdy_a), .resp_valid(vld_a), .resp_data(data_a),
        .resp_fault(fault_a), .req_dropped(drop_a)
    );

    dmem_responder #(.LATENCY(3)) u_dut_b (
        .CLK(clk), .RESET(rst),
        .req_enable(req_enable), .req_op(req_op), .req_mask(req_mask),
        .req_addr(req_addr), .req_data(req_data),
        .req_ready(rdy_b), .resp_valid(vld_b), .resp_data(data_b),
        .resp_fault(fault_b), .req_dropped(drop_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request (enable held for 1+hold edges), observe both responders for 6 cycles.
    task automatic send(input string tag, input logic [1:0] op, input logic [7:0] mask,
                        input logic [63:0] addr, input logic [63:0] data, input int hold,
                        input logic [63:0] exp_data, input logic [1:0] exp_fault);
        int          na = 0, nb = 0, ka = 0, kb = 0;
        logic [63:0] da = '0, db = '0;
        logic [1:0]  fa = '0, fb = '0;
        @(negedge clk);
        check({tag, " ready_a"}, 64'(rdy_a), 64'd1);
        check({tag, " ready_b"}, 64'(rdy_b), 64'd1);
        req_op     = op;
        req_mask   = mask;
        req_addr   = addr;
        req_data   = data;
        req_enable = 1'b1;
        rdy_hist_a = '0;
        rdy_hist_b = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            rdy_hist_a[k] = rdy_a;
            rdy_hist_b[k] = rdy_b;
            if (vld_a) begin na++; if (ka == 0) ka = k; da = data_a; fa = fault_a; end
            if (vld_b) begin nb++; if (kb == 0) kb = k; db = data_b; fb = fault_b; end
            if (k > hold) req_enable = 1'b0;
        end
        check({tag, " pulses_a"}, 64'(na), 64'd1);
        check({tag, " pulses_b"}, 64'(nb), 64'd1);
        check({tag, " lat_a"}, 64'(ka), 64'd1);
        check({tag, " lat_b"}, 64'(kb), 64'd3);
        check({tag, " data_a"}, da, exp_data);
        check({tag, " data_b"}, db, exp_data);
        check({tag, " fault_a"}, 64'(fa), 64'(exp_fault));
        check({tag, " fault_b"}, 64'(fb), 64'(exp_fault));
    endtask

    initial begin
        rst        = 1'b1;
        req_enable = 1'b0;
        req_op     = 2'b00;
        req_mask   = 8'h00;
        req_addr   = 64'h0;
        req_data   = 64'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst ready_a", 64'(rdy_a), 64'd0);
        check("rst ready_b", 64'(rdy_b), 64'd0);
        check("rst valid_b", 64'(vld_b), 64'd0);
        check("rst data_b", data_b, 64'h0);
        check("rst fault_b", 64'(fault_b), 64'd0);
        check("rst dropped_b", 64'(drop_b), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post-rst ready_a", 64'(rdy_a), 64'd1);
        check("post-rst ready_b", 64'(rdy_b), 64'd1);

        send("st full", 2'b01, 8'hFF, 64'h8000_0010, 64'h1122_3344_5566_7788, 0, 64'h0, 2'b00);
        send("ld full", 2'b00, 8'hFF, 64'h8000_0010, 64'h0, 0, 64'h1122_3344_5566_7788, 2'b00);

        send("st zero", 2'b01, 8'hFF, 64'h8000_0020, 64'h0, 0, 64'h0, 2'b00);
        send("st lo", 2'b01, 8'h0F, 64'h8000_0020, 64'hFFFF_FFFF_AABB_CCDD, 0, 64'h0, 2'b00);
        send("ld lo", 2'b00, 8'hFF, 64'h8000_0020, 64'h0, 0, 64'h0000_0000_AABB_CCDD, 2'b00);

        send("ld misal", 2'b00, 8'h01, 64'h8000_0001, 64'h0, 0, 64'h0, 2'b01);
        send("ld mask0", 2'b00, 8'h00, 64'h8000_0010, 64'h0, 0, 64'h0, 2'b01);
        send("st misal", 2'b01, 8'h01, 64'h8000_0011, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0, 2'b01);
        send("ld nowr", 2'b00, 8'hFF, 64'h8000_0010, 64'h0, 0, 64'h1122_3344_5566_7788, 2'b00);
        send("ld below", 2'b00, 8'hFF, 64'h7FFF_FFF8, 64'h0, 0, 64'h0, 2'b10);
        send("st above", 2'b01, 8'hFF, 64'h8000_2000, 64'h1, 0, 64'h0, 2'b10);
        send("op11", 2'b11, 8'h00, 64'h8000_0010, 64'h0, 0, 64'h0, 2'b11);

        send("st last", 2'b01, 8'hFF, 64'h8000_1FF8, 64'hDEAD_BEEF_0123_4567, 0, 64'h0, 2'b00);
        send("ld last hi", 2'b00, 8'hF0, 64'h8000_1FFC, 64'h0, 0, 64'hDEAD_BEEF_0000_0000, 2'b00);

        send("st nine", 2'b01, 8'hFF, 64'h8000_0040, 64'h9, 0, 64'h0, 2'b00);
`ifdef DMEM_RESPONDER_AMO_EN
        send("swap", 2'b10, 8'hFF, 64'h8000_0040, 64'h5, 0, 64'h9, 2'b00);
        send("ld swapped", 2'b00, 8'hFF, 64'h8000_0040, 64'h0, 0, 64'h5, 2'b00);
`else
        send("swap", 2'b10, 8'hFF, 64'h8000_0040, 64'h5, 0, 64'h0, 2'b11);
        send("ld swapped", 2'b00, 8'hFF, 64'h8000_0040, 64'h0, 0, 64'h9, 2'b00);
`endif

        check("pre-drop dropped_a", 64'(drop_a), 64'd0);
        check("pre-drop dropped_b", 64'(drop_b), 64'd0);
        send("ld drop", 2'b00, 8'hFF, 64'h8000_0010, 64'h0, 1, 64'h1122_3344_5566_7788, 2'b00);
        check("drop dropped_a", 64'(drop_a), 64'd1);
        check("drop dropped_b", 64'(drop_b), 64'd1);
        check("drop ready_a k1..2", 64'(rdy_hist_a[2:1]), 64'b10);
        check("drop ready_b k1..4", 64'(rdy_hist_b[4:1]), 64'b1000);

        // Load accepted, reset one cycle later: LATENCY=3 response must never appear.
        @(negedge clk);
        req_op     = 2'b00;
        req_mask   = 8'hFF;
        req_addr   = 64'h8000_0010;
        req_enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_enable = 1'b0;
        vld_cnt    = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst ready_b", 64'(rdy_b), 64'd0);
        check("midrst valid_b", 64'(vld_b), 64'd0);
        check("midrst data_b", data_b, 64'h0);
        check("midrst fault_b", 64'(fault_b), 64'd0);
        check("midrst dropped_a", 64'(drop_a), 64'd0);
        check("midrst dropped_b", 64'(drop_b), 64'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (vld_b) vld_cnt++;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst release ready_a", 64'(rdy_a), 64'd1);
        check("midrst release ready_b", 64'(rdy_b), 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (vld_b) vld_cnt++;
        end
        check("midrst no valid_b", 64'(vld_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side memory responder for a core's `memAction` request channel. It accepts one request at a time, carrying op, byte mask, address and store data. It performs the access against an internal doubleword RAM and returns a `{data, fault}` response after a configurable latency. It sits between the core's data-memory port and the system, beside the instruction fetch path.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 64-bit words; power of two, 2..65536.
- `BASE_ADDR`, 64'h0000_0000_8000_0000: byte address of word 0; aligned to `DEPTH_WORDS*8`.
- `LATENCY`, 1: cycles from request acceptance to `resp_valid`; range 1..4.

Ports:
- `CLK` in 1: the single clock; everything is on the rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `req_enable` in 1: a request is present this cycle.
- `req_op` in 2: 00 load, 01 store, 10 AMO swap, 11 reserved.
- `req_mask` in 8: byte-lane enables within the addressed doubleword.
- `req_addr` in 64: byte address.
- `req_data` in 64: store/swap data, lane-aligned.
- `req_ready` out 1: high when a request will be accepted this cycle.
- `resp_valid` out 1: one-cycle pulse; the response is valid.
- `resp_data` out 64: load/swap old data with unmasked lanes zeroed; 0 for stores and faults.
- `resp_fault` out 2: 00 ok, 01 misaligned, 10 access fault, 11 illegal op.
- `req_dropped` out 1: sticky; a request arrived while `req_ready` was low.

## Operation
- Acceptance: `req_enable && req_ready`. All request fields are sampled on that edge.
- Word index: `(req_addr - BASE_ADDR) >> 3`, computed in 64 bits.
- Access fault: the offset is ≥ `DEPTH_WORDS*8`, including negative offsets wrapping to large unsigned values.
- Fault priority: illegal op (11) > misaligned (01) > access (10).
- Illegal op: `req_op==11`, or `req_op==10` when AMO is compiled out.
- Misaligned: `req_mask==0`, or `req_mask[req_addr[2:0]]==0`.
- A faulting request never writes the RAM and still produces exactly one response.
- Store: masked lanes are written at the acceptance edge. `resp_data` = 0.
- Load: the RAM is read at acceptance. `resp_data` = word AND lane mask expanded to bytes.
- AMO swap: the old word is read and the masked lanes are written at the same acceptance edge. `resp_data` = old masked value.
- State machine:
  - IDLE: `req_ready`=1. On acceptance, if `LATENCY`==1 go to RESP; else go to WAIT with count=`LATENCY`-2.
  - WAIT: `req_ready`=0. Decrement the count; at 0 go to RESP.
  - RESP: `resp_valid`=1 for this cycle, `req_ready`=0, then return to IDLE.
- No backpressure on responses; the consumer is always ready.
- A request presented in WAIT or RESP is ignored and sets `req_dropped`. Only reset clears it.
- RAM contents are not reset.

## Timing
- Reset values: `req_ready`=0 while `RESET` is high and 1 in the first cycle after deassertion. `resp_valid`=0, `resp_data`=0, `resp_fault`=0, `req_dropped`=0. State = IDLE.
- Request accepted at edge N: `resp_valid` is high in cycle N+`LATENCY`. The next acceptance is possible at edge N+`LATENCY`+1.
- Throughput: one request per `LATENCY`+1 cycles.
- Read-after-write: a load accepted after a store sees the stored data, because the store commits at its own acceptance edge.
- Reset asserted mid-operation: the pending response is discarded with no `resp_valid`. A store or swap already accepted remains committed.
- `resp_data` and `resp_fault` are registered. They hold their last values outside `resp_valid`; consumers sample only when `resp_valid` is high.

## Configuration
- `DMEM_RESPONDER_AMO_EN`:
  - Defined: op 10 performs an atomic swap as above.
  - Undefined: op 10 returns fault 11, with no RAM write and `resp_data`=0. The swap datapath is not synthesized.

## Test plan
- Reset, then store `req_addr`=0x8000_0010, mask 0xFF, data 0x1122334455667788, then load the same address. Required: store response fault 00 with data 0; load response data 0x1122334455667788 at acceptance+`LATENCY`.
- Store mask 0x0F, data 0xFFFFFFFF_AABBCCDD over a word holding 0. Then load at the same address with mask 0xFF. Required: 0x00000000_AABBCCDD.
- Load at `req_addr`=0x8000_0001 with mask 0x01. Required: fault 01, no write. Load at 0x7FFF_FFF8 with mask 0xFF. Required: fault 10. Op 11 at a valid address with mask 0x00. Required: fault 11, because illegal op has priority.
- With AMO enabled: swap data 0x5 into a word holding 0x9 with mask 0xFF. Required: `resp_data`=0x9, and a following load returns 0x5. With AMO disabled, the same swap returns fault 11 and the word stays 0x9.
- With `LATENCY`=3: assert `req_enable` on consecutive cycles. Required: `req_ready` low for 3 cycles after acceptance, `req_dropped` set, exactly one `resp_valid` per accepted request.
- Accept a load with `LATENCY`=3, then assert `RESET` one cycle later. Required: no `resp_valid`, all outputs 0, and `req_ready`=1 one cycle after release.
